// File: rtl/fpmult_pkg.sv
// Shared constants and stage payload type for the pipelined fixed-point multiplier.
// The payload is sized for the widest supported word (n <= FP_N_MAX); narrower builds leave upper bits unused.
package fpmult_pkg;

  localparam logic RND_TRUNC  = 1'b0;
  localparam logic RND_HALFUP = 1'b1;

  localparam int FP_N_MAX = 64;
  localparam int FP_DW    = 2 * FP_N_MAX;

  typedef struct packed {
    logic             valid;
    logic             rnd;
    logic [FP_DW-1:0] data;
    logic             ovf;
  } fp_stage_t;

endpackage

// File: rtl/fpmult_round_sat.sv
// Round, rescale and range-check a full-width signed fixed-point product.
// Defining FPMULT_PIPE_SAT_EN clamps out-of-range results instead of wrapping them.
module fpmult_round_sat
  import fpmult_pkg::*;
#(
  parameter int n = 32,
  parameter int d = 16
) (
  input  logic [2*n-1:0] prod,
  input  logic           rnd,
  output logic [n-1:0]   c,
  output logic           ovf
);

  localparam int W = 2 * n + 1;
  localparam logic signed [W-1:0] HALF = {{(W-1){1'b0}}, 1'b1} << (d - 1);

  logic signed [W-1:0] ext_s;
  logic signed [W-1:0] sum_s;
  logic signed [W-1:0] q_s;
  logic [W-n:0]        top_s;

`ifdef FPMULT_PIPE_SAT_EN
  function automatic logic [n-1:0] clamp(input logic neg);
    clamp = neg ? {1'b1, {(n-1){1'b0}}} : {1'b0, {(n-1){1'b1}}};
  endfunction
`endif

  // One extra bit keeps the half-LSB add from overflowing; q fits iff its top bits are a pure sign run.
  always_comb begin
    ext_s = $signed({prod[2*n-1], prod});
    case (rnd)
      RND_TRUNC:  sum_s = ext_s;
      RND_HALFUP: sum_s = ext_s + HALF;
      default:    sum_s = ext_s;
    endcase
    q_s   = sum_s >>> d;
    top_s = q_s[W-1:n-1];
    ovf   = !((&top_s) || !(|top_s));
`ifdef FPMULT_PIPE_SAT_EN
    if (ovf) begin
      c = clamp(q_s[W-1]);
    end else begin
      c = q_s[n-1:0];
    end
`else
    c = q_s[n-1:0];
`endif
  end

endmodule

// File: rtl/fpmult_pipe.sv
// Fully pipelined signed fixed-point multiplier (latency P) with val/rdy on both sides.
// Defining FPMULT_PIPE_SAT_EN makes overflowing results saturate; otherwise they wrap.
module fpmult_pipe
  import fpmult_pkg::*;
#(
  parameter int n = 32,
  parameter int d = 16,
  parameter int P = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           recv_val,
  output logic           recv_rdy,
  input  logic [2*n-1:0] recv_msg,
  input  logic           recv_rnd,
  output logic           send_val,
  input  logic           send_rdy,
  output logic [n-1:0]   send_msg,
  output logic           send_ovf
);

  localparam int SRD = (P >= 2) ? P - 2 : 0;

  fp_stage_t             st_r     [P];
  fp_stage_t             st_nxt_s [P];
  logic                  stall_s;
  logic signed [n-1:0]   mul_a_s;
  logic signed [n-1:0]   mul_b_s;
  logic signed [2*n-1:0] prod_s;
  logic [2*n-1:0]        rin_s;
  logic                  rin_rnd_s;
  logic [n-1:0]          c_s;
  logic                  ovf_s;
  logic                  unused_s;

  assign stall_s  = st_r[P-1].valid & ~send_rdy;
  assign recv_rdy = ~stall_s;
  assign send_val = st_r[P-1].valid;
  assign send_msg = st_r[P-1].data[n-1:0];
  assign send_ovf = st_r[P-1].ovf;

  // A one-deep pipe multiplies straight from the port; deeper pipes multiply out of stage 0.
  always_comb begin
    if (P == 1) begin
      mul_a_s = recv_msg[2*n-1:n];
      mul_b_s = recv_msg[n-1:0];
    end else begin
      mul_a_s = st_r[0].data[2*n-1:n];
      mul_b_s = st_r[0].data[n-1:0];
    end
    prod_s = (2*n)'(mul_a_s) * (2*n)'(mul_b_s);
    if (P >= 3) begin
      rin_s     = st_r[SRD].data[2*n-1:0];
      rin_rnd_s = st_r[SRD].rnd;
    end else if (P == 2) begin
      rin_s     = prod_s;
      rin_rnd_s = st_r[0].rnd;
    end else begin
      rin_s     = prod_s;
      rin_rnd_s = recv_rnd;
    end
  end

  fpmult_round_sat #(.n(n), .d(d)) u_round_sat (
    .prod (rin_s),
    .rnd  (rin_rnd_s),
    .c    (c_s),
    .ovf  (ovf_s)
  );

  // Stage payload next-state: operands in, product after the first hop, final c/ovf on the last.
  always_comb begin
    st_nxt_s[0] = '{valid: recv_val, rnd: recv_rnd, data: FP_DW'(recv_msg), ovf: 1'b0};
    for (int i = 1; i < P; i++) begin
      st_nxt_s[i] = st_r[i-1];
      if (i == 1 && P >= 3) begin
        st_nxt_s[i].data = FP_DW'($unsigned(prod_s));
      end else begin
        st_nxt_s[i].data = st_r[i-1].data;
      end
    end
    st_nxt_s[P-1].data = FP_DW'(c_s);
    st_nxt_s[P-1].ovf  = ovf_s;
  end

  // The whole pipe, bubbles included, advances together unless the output is stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < P; i++) st_r[i] <= '0;
    end else if (!stall_s) begin
      for (int i = 0; i < P; i++) st_r[i] <= st_nxt_s[i];
    end else begin
      for (int i = 0; i < P; i++) st_r[i] <= st_r[i];
    end
  end

  // Payload bits beyond the live width are never read downstream.
  always_comb begin
    unused_s = 1'b0;
    for (int i = 0; i < P; i++) unused_s = unused_s ^ (^st_r[i]);
  end

endmodule

// File: tb/tb_fpmult_pipe.sv
// Bench for fpmult_pipe: a P=3 and a P=1 instance share clock and reset, each with its own scoreboard.
// Expected results are directed constants or come from a longint reference model.
module tb_fpmult_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  recv_val, recv_rdy, recv_rnd, send_val, send_rdy, send_ovf;
  logic [63:0] recv_msg [2];
  logic [31:0] send_msg [2];

  logic [32:0] sb0_q [$];
  logic [32:0] sb1_q [$];
  int n_pass = 0;
  int n_chk  = 0;
  int n_fail = 0;
  int n_out [2];

  logic        f, sv, rr, pf, stale, sr_t;
  logic [31:0] sm, held, a_v, b_v;
  int          lat, k, base;

`ifdef FPMULT_PIPE_SAT_EN
  localparam logic [32:0] EXP_OVF_POS = {1'b1, 32'h7FFFFFFF};
  localparam logic [32:0] EXP_OVF_NEG = {1'b1, 32'h80000000};
`else
  localparam logic [32:0] EXP_OVF_POS = {1'b1, 32'hFFFE0000};
  localparam logic [32:0] EXP_OVF_NEG = {1'b1, 32'h00000000};
`endif

  always #5 clk = ~clk;

  fpmult_pipe #(.n(32), .d(16), .P(3)) dut3 (
    .clk(clk), .reset(reset),
    .recv_val(recv_val[0]), .recv_rdy(recv_rdy[0]), .recv_msg(recv_msg[0]), .recv_rnd(recv_rnd[0]),
    .send_val(send_val[0]), .send_rdy(send_rdy[0]), .send_msg(send_msg[0]), .send_ovf(send_ovf[0])
  );

  fpmult_pipe #(.n(32), .d(16), .P(1)) dut1 (
    .clk(clk), .reset(reset),
    .recv_val(recv_val[1]), .recv_rdy(recv_rdy[1]), .recv_msg(recv_msg[1]), .recv_rnd(recv_rnd[1]),
    .send_val(send_val[1]), .send_rdy(send_rdy[1]), .send_msg(send_msg[1]), .send_ovf(send_ovf[1])
  );

  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b, input logic r);
    longint p, q;
    logic ovf;
    logic [31:0] c;
    p = longint'($signed(a)) * longint'($signed(b));
    if (r) p = p + 64'sd32768;
    q = p >>> 16;
    ovf = (q > 64'sd2147483647) || (q < -64'sd2147483648);
    c = q[31:0];
`ifdef FPMULT_PIPE_SAT_EN
    if (ovf) c = (q > 64'sd0) ? 32'h7FFFFFFF : 32'h80000000;
`endif
    return {ovf, c};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input int u);
    logic [32:0] e;
    int sz;
    sz = (u == 0) ? sb0_q.size() : sb1_q.size();
    n_chk++;
    assert (sz != 0) n_pass++;
    else begin
      n_fail++;
      $error("FAIL unexpected_out_u%0d: observed %0h expected no output", u, {send_ovf[u], send_msg[u]});
    end
    if (sz != 0) begin
      if (u == 0) e = sb0_q.pop_front();
      else e = sb1_q.pop_front();
      chk($sformatf("result_u%0d", u), 64'({send_ovf[u], send_msg[u]}), 64'(e));
    end
    n_out[u]++;
  endtask

  // One clock: drive unit u, idle the other, sample at negedge, score outputs, log the fire.
  task automatic tick(input int u, input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic r, input logic sr, input logic [32:0] exp,
                      output logic fired, output logic sval, output logic rrdy, output logic [31:0] smsg);
    for (int j = 0; j < 2; j++) begin
      recv_val[j] = 1'b0;
      send_rdy[j] = 1'b1;
    end
    recv_val[u] = v;
    recv_msg[u] = {a, b};
    recv_rnd[u] = r;
    send_rdy[u] = sr;
    @(negedge clk);
    sval  = send_val[u];
    rrdy  = recv_rdy[u];
    smsg  = send_msg[u];
    fired = recv_val[u] && recv_rdy[u];
    for (int j = 0; j < 2; j++)
      if (send_val[j] && send_rdy[j]) pop_chk(j);
    if (fired) begin
      if (u == 0) sb0_q.push_back(exp);
      else sb1_q.push_back(exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send1(input int u, input logic [31:0] a, input logic [31:0] b, input logic r,
                       input logic [32:0] exp);
    logic fo, so, ro;
    logic [31:0] mo;
    tick(u, 1'b1, a, b, r, 1'b1, exp, fo, so, ro, mo);
    chk($sformatf("fire_u%0d", u), 64'(fo), 64'(1));
  endtask

  task automatic idle(input int nc);
    logic fo, so, ro;
    logic [31:0] mo;
    for (int i = 0; i < nc; i++) tick(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 33'h0, fo, so, ro, mo);
  endtask

  task automatic wait_out(input int u, output int l);
    logic fo, so, ro;
    logic [31:0] mo;
    l = -1;
    for (int i = 1; i <= 20 && l < 0; i++) begin
      tick(u, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 33'h0, fo, so, ro, mo);
      if (so) l = i;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_out[0] = 0;
    n_out[1] = 0;
    reset    = 1'b0;
    recv_val = 2'b00;
    recv_rnd = 2'b00;
    send_rdy = 2'b11;
    recv_msg[0] = 64'h0;
    recv_msg[1] = 64'h0;

    // Reset state
    @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("rst_val_u%0d", u), 64'(send_val[u]), 64'(0));
      chk($sformatf("rst_msg_u%0d", u), 64'(send_msg[u]), 64'(0));
      chk($sformatf("rst_ovf_u%0d", u), 64'(send_ovf[u]), 64'(0));
      chk($sformatf("rst_rdy_u%0d", u), 64'(recv_rdy[u]), 64'(1));
    end
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Basic products and P=3 latency
    send1(0, 32'h00018000, 32'h00020000, 1'b0, {1'b0, 32'h00030000});
    wait_out(0, lat);
    chk("lat_p3", 64'(lat), 64'(3));
    send1(0, 32'hFFFE8000, 32'h00020000, 1'b0, {1'b0, 32'hFFFD0000});
    wait_out(0, lat);
    chk("lat_p3_neg", 64'(lat), 64'(3));

    // Rounding
    send1(0, 32'h00000001, 32'h00008000, 1'b0, {1'b0, 32'h00000000});
    send1(0, 32'h00000001, 32'h00008000, 1'b1, {1'b0, 32'h00000001});
    send1(0, 32'hFFFFFFFF, 32'h00008000, 1'b1, {1'b0, 32'h00000000});
    idle(5);

    // Overflow on both depths
    send1(0, 32'h7FFF0000, 32'h00020000, 1'b0, EXP_OVF_POS);
    send1(0, 32'h80000000, 32'h00020000, 1'b0, EXP_OVF_NEG);
    idle(5);
    send1(1, 32'h7FFF0000, 32'h00020000, 1'b0, EXP_OVF_POS);
    send1(1, 32'h80000000, 32'h00020000, 1'b0, EXP_OVF_NEG);
    idle(3);

    // Backpressure: 10 back-to-back with send_rdy low for 5 cycles
    base = n_out[0];
    k = 1;
    held = 32'h0;
    for (int t = 0; t < 40 && k <= 10; t++) begin
      sr_t = !(t >= 6 && t <= 10);
      a_v = 32'(k) << 16;
      tick(0, 1'b1, a_v, 32'h00010000, 1'b0, sr_t, model(a_v, 32'h00010000, 1'b0), f, sv, rr, sm);
      if (t == 6) held = sm;
      if (!sr_t) begin
        chk("stall_val", 64'(sv), 64'(1));
        chk("stall_rdy", 64'(rr), 64'(0));
      end
      if (t > 6 && !sr_t) chk("stall_hold", 64'(sm), 64'(held));
      if (f) k++;
    end
    idle(6);
    chk("bp_all_sent", 64'(k), 64'(11));
    chk("bp_count", 64'(n_out[0] - base), 64'(10));
    chk("bp_sb_empty", 64'(sb0_q.size()), 64'(0));

    // P=1: latency and streaming with send_rdy toggling
    send1(1, 32'h00018000, 32'h00020000, 1'b0, {1'b0, 32'h00030000});
    wait_out(1, lat);
    chk("lat_p1", 64'(lat), 64'(1));
    base = n_out[1];
    k = 1;
    pf = 1'b0;
    a_v = $urandom;
    b_v = $urandom;
    for (int t = 0; t < 60 && k <= 8; t++) begin
      sr_t = (t % 2 == 1);
      tick(1, 1'b1, a_v, b_v, k[0], sr_t, model(a_v, b_v, k[0]), f, sv, rr, sm);
      if (pf) chk("p1_next_val", 64'(sv), 64'(1));
      pf = f;
      if (f) begin
        k++;
        a_v = $urandom;
        b_v = $urandom;
      end
    end
    idle(3);
    chk("p1_count", 64'(n_out[1] - base), 64'(8));
    chk("p1_sb_empty", 64'(sb1_q.size()), 64'(0));

    // Reset with three transactions in flight
    send1(0, 32'h00030000, 32'h00020000, 1'b0, {1'b0, 32'h00060000});
    send1(0, 32'h00040000, 32'h00020000, 1'b0, {1'b0, 32'h00080000});
    send1(0, 32'h00050000, 32'h00020000, 1'b0, {1'b0, 32'h000A0000});
    chk("rst_pre_val", 64'(send_val[0]), 64'(1));
    #2;
    reset = 1'b0;
    #1;
    chk("rst_async_val", 64'(send_val[0]), 64'(0));
    chk("rst_async_msg", 64'(send_msg[0]), 64'(0));
    chk("rst_async_ovf", 64'(send_ovf[0]), 64'(0));
    sb0_q.delete();
    sb1_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 33'h0, f, sv, rr, sm);
      if (sv) stale = 1'b1;
    end
    chk("rst_no_stale", 64'(stale), 64'(0));
    send1(0, 32'hFFFF0000, 32'h00030000, 1'b0, {1'b0, 32'hFFFD0000});
    wait_out(0, lat);
    chk("lat_after_rst", 64'(lat), 64'(3));
    idle(3);
    chk("end_sb0_empty", 64'(sb0_q.size()), 64'(0));
    chk("end_sb1_empty", 64'(sb1_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fpmult_pipe.md
Name: fpmult_pipe

Overview:
Parametrised, fully pipelined signed fixed-point multiplier with val/rdy on both sides. It is the next generation of the team's single-shot fixed-point multiplier harness. It adds configurable pipeline depth, per-transaction rounding mode, an overflow flag and optional saturation. It sits between the transform datapath producers and consumers, accepting one {a,b} pair per cycle at full throughput.

Parameters:
n  32  total word width in bits, two's complement; n >= 4
d  16  fractional bits; 0 < d < n
P  3   pipeline depth in stages (= latency in cycles); P >= 1

Ports:
clk        in   1    clock, rising edge
reset      in   1    asynchronous, active-low reset
recv_val   in   1    input transaction valid
recv_rdy   out  1    block can accept input this cycle
recv_msg   in   2n   {a[2n-1:n], b[n-1:0]}, both signed Qn-d.d
recv_rnd   in   1    0 = truncate (floor), 1 = round-half-up; qualified by recv_val
send_val   out  1    output valid
send_rdy   in   1    consumer ready
send_msg   out  n    product c, signed Qn-d.d
send_ovf   out  1    result did not fit in n bits (wrapped, or clamped when saturating)

Behaviour:
- Reset (reset=0, async assert, sync deassert edge at clk): all stage valid bits = 0; all data/flag registers = 0. So send_val=0, send_msg=0, send_ovf=0 during and after reset. Reset mid-stream discards all in-flight transactions; none reappear.
- Fire rules: input fire = recv_val && recv_rdy; output fire = send_val && send_rdy.
- Stall: stall = send_val && !send_rdy. recv_rdy = !stall (combinational from send_rdy).
- While stalled, every stage register holds, including bubbles; no bubble collapsing.
- When not stalled, all stages advance one step. Stage 0 loads {a, b, rnd, valid=recv_val}.
- send_val = valid bit of stage P-1.
- Latency: exactly P cycles from input fire to send_val, with no backpressure. Throughput is 1 result per cycle. Order is strictly FIFO.
- Output holds: send_msg and send_ovf stay stable while send_val && !send_rdy.
- Arithmetic:
  - prod = signed(a) * signed(b), full 2n bits.
  - If rnd=1: prod += 2^(d-1). Use 2n+1 bits internally so the add cannot overflow.
  - q = prod >>> d (arithmetic shift).
  - ovf = 1 iff q is outside [-2^(n-1), 2^(n-1)-1].
  - Default c = q[n-1:0] (wrap).
- Retiming: the multiply and round/shift/saturate may be placed in any stages, provided latency is exactly P and the combinational path per stage is at most one n x n multiply.
- P=1: a single registered stage; a result is visible the cycle after input fire.
- Simultaneous output fire and input fire in the same cycle is legal. The pipeline advances; no loss, no duplication.
- recv_rnd is sampled only on input fire and travels with its operands.

Optional Feature:
Macro FPMULT_PIPE_SAT_EN.
- Defined: when ovf=1, c clamps to 2^(n-1)-1 (q > 0) or -2^(n-1) (q < 0); send_ovf=1.
- Undefined: c wraps (low n bits of q); send_ovf is still reported.
- Latency and handshake are identical in both builds.

Decomposition:
- Package fpmult_pkg:
  - localparams RND_TRUNC=1'b0 and RND_HALFUP=1'b1.
  - Packed struct type for the stage payload {valid, rnd, a, b / partial product, ovf}, widths derived from n.
- One sub-module, fpmult_round_sat: combinational, takes the 2n-bit product and rnd; outputs n-bit c and ovf; honours FPMULT_PIPE_SAT_EN.
- Pipeline registers and the val/rdy control live in fpmult_pipe.

Test Plan:
1. n=32, d=16, P=3, send_rdy=1: a=0x00018000, b=0x00020000, rnd=0 -> send_msg=0x00030000, ovf=0, exactly 3 cycles after fire. a=0xFFFE8000 (-1.5) x 0x00020000 -> 0xFFFD0000.
2. Rounding: a=0x00000001, b=0x00008000. rnd=0 -> 0x00000000. rnd=1 -> 0x00000001. a=0xFFFFFFFF, same b, rnd=1 -> 0x00000000.
3. Overflow: a=0x7FFF0000, b=0x00020000. With SAT -> 0x7FFFFFFF, ovf=1. Without SAT -> 0xFFFE0000, ovf=1. a=0x80000000 x 0x00020000 with SAT -> 0x80000000, ovf=1.
4. Backpressure: stream 10 back-to-back products (a=k<<16, b=0x00010000, k=1..10). Drop send_rdy for 5 cycles mid-stream -> recv_rdy=0 during the stall, send_msg held stable, all 10 results in order, none lost or duplicated.
5. P=1 build: streaming with send_rdy toggling every cycle -> results arrive 1 cycle after fire, correct order.
6. Reset mid-operation: assert reset with 3 transactions in flight -> send_val=0 and send_msg=0 immediately (async). After release, no stale outputs; a new transaction completes correctly.
